// File: rtl/div3_rom_ctrl.sv
// rtl/div3_rom_ctrl.sv - fills a divide-by-3 lookup table after reset, then serves quotient/remainder requests from it.
// Optional DIV3_SELFCHECK_EN: verifies each looked-up word against the operand and raises a sticky err_o.
module div3_rom_ctrl #(
   parameter int MEM_SIZE = 6,
   parameter int DATA_W   = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [MEM_SIZE-1:0] req_operand_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [MEM_SIZE-2:0] rsp_quot_o,
   output logic [1:0]          rsp_rem_o,
   output logic                init_done_o,
   output logic                err_o,
   output logic                mem_write_o,
   output logic [MEM_SIZE-1:0] mem_addr_w_o,
   output logic [DATA_W-1:0]   mem_datain_o,
   output logic                mem_read_o,
   output logic [MEM_SIZE-1:0] mem_addr_r_o,
   input  logic [DATA_W-1:0]   mem_dataout_i
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [MEM_SIZE-1:0] cnt_q, cnt_d;
   logic [MEM_SIZE-2:0] q_q, q_d;
   logic [1:0]          r_q, r_d;
   logic [MEM_SIZE-2:0] quot_q, quot_d;
   logic [1:0]          rem_q, rem_d;
   logic                init_done_q, init_done_d;
   logic                unused_dataout;

   assign unused_dataout = ^mem_dataout_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         q_q         <= '0;
         r_q         <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         r_q         <= r_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         init_done_q <= init_done_d;
      end
   end

   // Running q/r counters produce addr/3 and addr%3 without a divider.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      q_d         = q_q;
      r_d         = r_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      init_done_d = init_done_q;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (r_q == 2'd2) begin
               r_d = 2'd0;
               q_d = q_q + 1'b1;
            end else begin
               r_d = r_q + 2'd1;
            end
            if (cnt_q == {MEM_SIZE{1'b1}}) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end
         end
         S_IDLE: begin
            if (req_valid_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            quot_d  = mem_dataout_i[MEM_SIZE:2];
            rem_d   = mem_dataout_i[1:0];
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
   end

   // Outputs are forced low while rst_i is asserted.
   always_comb begin
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_w_o = '0;
      mem_datain_o = '0;
      mem_read_o   = 1'b0;
      mem_addr_r_o = '0;
      if (!rst_i) begin
         case (state_q)
            S_INIT: begin
               mem_write_o             = 1'b1;
               mem_addr_w_o            = cnt_q;
               mem_datain_o[MEM_SIZE:0] = {q_q, r_q};
            end
            S_IDLE: begin
               req_ready_o = 1'b1;
               if (req_valid_i) begin
                  mem_read_o   = 1'b1;
                  mem_addr_r_o = req_operand_i;
               end
            end
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign rsp_quot_o  = quot_q;
   assign rsp_rem_o   = rem_q;
   assign init_done_o = init_done_q;

`ifdef DIV3_SELFCHECK_EN
   logic [MEM_SIZE-1:0] operand_q;
   logic                err_q;
   logic [MEM_SIZE+1:0] recon;
   logic                mismatch;

   always_comb begin
      recon    = ({3'b000, mem_dataout_i[MEM_SIZE:2]} * (MEM_SIZE+2)'(3))
               + {{MEM_SIZE{1'b0}}, mem_dataout_i[1:0]};
      mismatch = (recon != {2'b00, operand_q}) || (mem_dataout_i[1:0] == 2'd3);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         operand_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == S_IDLE && req_valid_i) operand_q <= req_operand_i;
         if (state_q == S_WAIT && mismatch) err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_div3_rom_ctrl.sv
// tb/tb_div3_rom_ctrl.sv - self-checking bench for div3_rom_ctrl with a behavioural table memory.
module tb_div3_rom_ctrl;
   localparam int MS    = 6;
   localparam int DW    = 10;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [MS-1:0] req_operand = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [MS-2:0] rsp_quot;
   logic [1:0]    rsp_rem;
   logic          init_done;
   logic          err;
   logic          mem_write;
   logic [MS-1:0] mem_addr_w;
   logic [DW-1:0] mem_datain;
   logic          mem_read;
   logic [MS-1:0] mem_addr_r;
   logic [DW-1:0] mem_dataout;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_q;
   logic          corrupt = 1'b0;
   logic [DW-1:0] bad_word = 10'd9;
   logic          err_seen = 1'b0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [MS-1:0] op;
      logic [MS-2:0] q;
      logic [1:0]    r;
      int            stall;
   } vec_t;

   typedef struct {
      logic [MS-2:0] q;
      logic [1:0]    r;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr_w] <= mem_datain;
      if (mem_read) rd_q <= mem[mem_addr_r];
   end
   assign mem_dataout = corrupt ? bad_word : rd_q;

   always @(negedge clk) if (err === 1'b1) err_seen = 1'b1;

   div3_rom_ctrl #(.MEM_SIZE(MS), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operand_i(req_operand),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_quot_o(rsp_quot), .rsp_rem_o(rsp_rem),
      .init_done_o(init_done), .err_o(err),
      .mem_write_o(mem_write), .mem_addr_w_o(mem_addr_w), .mem_datain_o(mem_datain),
      .mem_read_o(mem_read), .mem_addr_r_o(mem_addr_r), .mem_dataout_i(mem_dataout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_check(input bit hold);
      int bad = 0;
      int busy = 0;
      logic [DW-1:0] d5 = '0;
      logic [DW-1:0] d63 = '0;
      logic [DW-1:0] e;
      for (int i = 0; i < DEPTH; i++) begin
         req_valid = hold;
         req_operand = 6'(i);
         #1;
         e = DW'(((i / 3) << 2) | (i % 3));
         if (mem_write !== 1'b1 || mem_addr_w !== 6'(i) || mem_datain !== e) bad++;
         if (req_ready !== 1'b0 || mem_read !== 1'b0 || init_done !== 1'b0) busy++;
         if (i == 5) d5 = mem_datain;
         if (i == 63) d63 = mem_datain;
         tick();
      end
      req_valid = 1'b0;
      #1;
      check("fill_entries_bad", bad, 0);
      check("fill_blocked_bad", busy, 0);
      check("fill_addr5", d5, 32'b0000000110);
      check("fill_addr63", d63, (21 << 2) | 0);
      check("fill_end_write", mem_write, 0);
      check("init_done", init_done, 1);
      check("idle_ready", req_ready, 1);
   endtask

   task automatic do_req(input vec_t v);
      exp_t x;
      int n;
      int unstable = 0;
      logic [MS-2:0] q0;
      logic [1:0] r0;
      req_valid = 1'b1;
      req_operand = v.op;
      rsp_ready = (v.stall == 0);
      #1;
      check("accept_ready", req_ready, 1);
      check("accept_read", mem_read, 1);
      check("accept_addr_r", mem_addr_r, v.op);
      check("accept_no_write", mem_write, 0);
      x.q = v.q;
      x.r = v.r;
      sb.push_back(x);
      tick();
      req_valid = 1'b0;
      #1;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 10) begin
         tick();
         #1;
         n++;
      end
      check("rsp_latency", n, 2);
      q0 = rsp_quot;
      r0 = rsp_rem;
      for (int s = 0; s < v.stall; s++) begin
         if (rsp_valid !== 1'b1 || rsp_quot !== q0 || rsp_rem !== r0 || req_ready !== 1'b0)
            unstable++;
         tick();
         if (s == v.stall - 1) rsp_ready = 1'b1;
         #1;
      end
      if (v.stall > 0) check("stall_hold_bad", unstable, 0);
      x = sb.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_quot", rsp_quot, x.q);
      check("rsp_rem", rsp_rem, x.r);
      tick();
      rsp_ready = 1'b0;
      #1;
      check("rsp_drop", rsp_valid, 0);
      check("back_idle", req_ready, 1);
   endtask

   initial begin
      int n;
      vecs[0] = '{6'd0,  5'd0,  2'd0, 0};
      vecs[1] = '{6'd47, 5'd15, 2'd2, 0};
      vecs[2] = '{6'd63, 5'd21, 2'd0, 0};
      vecs[3] = '{6'd10, 5'd3,  2'd1, 5};
      vecs[4] = '{6'd1,  5'd0,  2'd1, 0};
      vecs[5] = '{6'd32, 5'd10, 2'd2, 2};
      vecs[6] = '{6'd62, 5'd20, 2'd2, 0};

      tick();
      tick();
      #1;
      check("reset_outputs", {req_ready, rsp_valid, init_done, err, mem_write, mem_read,
                              mem_addr_w, mem_datain, mem_addr_r, rsp_quot, rsp_rem}, 0);
      rst = 1'b0;
      fill_check(1'b1);

      for (int i = 0; i < 7; i++) do_req(vecs[i]);

      // Reset in the middle of the fill.
      tick();
      n = 0;
      while (mem_write !== 1'b1 && n < 5) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n = 0;
      while (mem_addr_w !== 6'd30 && n < 100) begin
         tick();
         #1;
         n++;
      end
      check("reach_addr30", mem_addr_w, 30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("midfill_init_done", init_done, 0);
      check("midfill_restart_addr", mem_addr_w, 0);
      check("midfill_restart_write", mem_write, 1);
      fill_check(1'b0);

      // Reset while a response is pending.
      req_valid = 1'b1;
      req_operand = 6'd20;
      rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      #1;
      check("resp_pending", rsp_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("resp_rst_valid", rsp_valid, 0);
      check("resp_rst_init_done", init_done, 0);
      check("resp_rst_addr", mem_addr_w, 0);
      fill_check(1'b0);
      sb.delete();
      do_req(vecs[2]);

`ifdef DIV3_SELFCHECK_EN
      req_valid = 1'b1;
      req_operand = 6'd9;
      rsp_ready = 1'b0;
      corrupt = 1'b1;
      #1;
      check("err_before", err, 0);
      tick();
      req_valid = 1'b0;
      #1;
      check("err_in_wait", err, 0);
      tick();
      #1;
      check("err_set", err, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      corrupt = 1'b0;
      repeat (3) tick();
      #1;
      check("err_sticky", err, 1);
      rst = 1'b1;
      tick();
      #1;
      check("err_cleared", err, 0);
      rst = 1'b0;
      fill_check(1'b0);
`else
      check("err_never_set", err_seen, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
